// File: rtl/dmem_access_ctrl_pkg.sv
// Shared codes and types for the MEM-stage data memory access controller.
// Size codes, one-hot state encodings, default timeout and the latched request.
package dmem_access_ctrl_pkg;

    localparam logic [1:0] MEM_SIZE_B   = 2'b00;
    localparam logic [1:0] MEM_SIZE_H   = 2'b01;
    localparam logic [1:0] MEM_SIZE_W   = 2'b10;
    localparam logic [1:0] MEM_SIZE_ILL = 2'b11;

    localparam int DMEM_TIMEOUT = 16;

    typedef enum logic [3:0] {
        DMEM_IDLE   = 4'b0001,
        DMEM_REQ    = 4'b0010,
        DMEM_WAIT_R = 4'b0100,
        DMEM_DONE   = 4'b1000
    } dmem_state_e;

    typedef struct packed {
        logic       we;
        logic [1:0] size;
        logic       uns;
    } dmem_ctrl_t;

    // Accesses that can never reach the bus: misaligned half/word or the illegal size.
    function automatic logic dmem_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (size)
            MEM_SIZE_H:   bad = off[0];
            MEM_SIZE_W:   bad = (off != 2'b00);
            MEM_SIZE_ILL: bad = 1'b1;
            default:      bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Single-port data memory bus with req/gnt/rvalid handshake.
// master = access controller, slave = memory.
interface dmem_access_ctrl_if #(
    parameter int XLEN = 32
);
    logic            req;
    logic            we;
    logic [3:0]      be;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/dmem_access_ctrl_lane_align.sv
// Byte-lane steering for RV32I loads/stores: byte enables, store replication,
// load alignment with sign/zero extension. Purely combinational.
module dmem_lane_align
    import dmem_access_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      size,
    input  logic            uns,
    input  logic [1:0]      off,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata_rep,
    output logic [XLEN-1:0] rdata_ext
);

    logic [XLEN-1:0] shifted;

    assign shifted = rdata >> {off, 3'b000};

    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = shifted;
        case (size)
            MEM_SIZE_B: begin
                be        = 4'b0001 << off;
                wdata_rep = {(XLEN/8){wdata[7:0]}};
                rdata_ext = {{(XLEN-8){~uns & shifted[7]}}, shifted[7:0]};
            end
            MEM_SIZE_H: begin
                be        = 4'b0011 << off;
                wdata_rep = {(XLEN/16){wdata[15:0]}};
                rdata_ext = {{(XLEN-16){~uns & shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage load/store sequencer onto a single-port data memory.
// Stalls the pipeline per access and reports misalignment, illegal size or timeout.
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = DMEM_TIMEOUT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cpu_valid,
    input  logic            cpu_we,
    input  logic [1:0]      cpu_size,
    input  logic            cpu_unsigned,
    input  logic [XLEN-1:0] cpu_addr,
    input  logic [XLEN-1:0] cpu_wdata,
    output logic            stall,
    output logic            cpu_done,
    output logic [XLEN-1:0] cpu_rdata,
    output logic            cpu_err,
    dmem_access_ctrl_if.master dm
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    dmem_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dmem_ctrl_t      ctrl_q, ctrl_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            err_q, err_d;

    logic            stall_c, done_c, req_c;
    logic            timeout_hit;
    logic [CNT_W-1:0] cnt_inc;
    logic [3:0]      be_lane;
    logic [XLEN-1:0] wdata_rep, rdata_ext;

    dmem_lane_align #(.XLEN(XLEN)) u_align (
        .size      (ctrl_q.size),
        .uns       (ctrl_q.uns),
        .off       (addr_q[1:0]),
        .wdata     (wdata_q),
        .rdata     (dm.rdata),
        .be        (be_lane),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext)
    );

    // Saturate so a stalled WAIT_R past the limit keeps timing out instead of wrapping.
    assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign timeout_hit = TIMEOUT_EN && (cnt_q >= CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl_d  = ctrl_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        stall_c = 1'b0;
        done_c  = 1'b0;
        req_c   = 1'b0;
        case (state_q)
            DMEM_IDLE: begin
                stall_c = cpu_valid;
                if (cpu_valid) begin
                    ctrl_d  = '{we: cpu_we, size: cpu_size, uns: cpu_unsigned};
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    rdata_d = '0;
                    cnt_d   = '0;
                    if (dmem_misaligned(cpu_size, cpu_addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = DMEM_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = DMEM_REQ;
                    end
                end
            end
            DMEM_REQ: begin
                req_c   = 1'b1;
                stall_c = 1'b1;
                cnt_d   = cnt_inc;
                if (dm.gnt) begin
                    state_d = ctrl_q.we ? DMEM_DONE : DMEM_WAIT_R;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = DMEM_DONE;
                end
            end
            DMEM_WAIT_R: begin
                stall_c = 1'b1;
                cnt_d   = cnt_inc;
                if (dm.rvalid) begin
                    rdata_d = rdata_ext;
                    state_d = DMEM_DONE;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = DMEM_DONE;
                end
            end
            DMEM_DONE: begin
                done_c  = 1'b1;
                state_d = DMEM_IDLE;
            end
            default: state_d = DMEM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DMEM_IDLE;
            cnt_q   <= '0;
            ctrl_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Reset masks every output, including the combinational stall.
    assign stall     = ~reset & stall_c;
    assign cpu_done  = ~reset & done_c;
    assign cpu_err   = ~reset & done_c & err_q;
    assign cpu_rdata = reset ? '0 : rdata_q;

    assign dm.req   = ~reset & req_c;
    assign dm.we    = dm.req & ctrl_q.we;
    assign dm.be    = dm.req ? (ctrl_q.we ? be_lane : 4'b1111) : 4'b0000;
    assign dm.addr  = dm.req ? {addr_q[XLEN-1:2], 2'b00} : '0;
    assign dm.wdata = (dm.req & ctrl_q.we) ? wdata_rep : '0;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: vector table of single accesses plus
// hand-written timeout and mid-access reset sequences.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_valid, cpu_we, cpu_unsigned;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        stall, cpu_done, cpu_err;
    logic [31:0] cpu_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_access_ctrl_if #(.XLEN(32)) dm_if ();

    dmem_access_ctrl #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_valid    (cpu_valid),
        .cpu_we       (cpu_we),
        .cpu_size     (cpu_size),
        .cpu_unsigned (cpu_unsigned),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .stall        (stall),
        .cpu_done     (cpu_done),
        .cpu_rdata    (cpu_rdata),
        .cpu_err      (cpu_err),
        .dm           (dm_if)
    );

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                       input logic [3:0] be, input logic [31:0] ea, input logic [31:0] ew,
                       input logic [31:0] er, input logic err, input int lat);
        vec_t v;
        v = '{nm, we, size, uns, addr, wdata, rdata, be, ea, ew, er, err, lat};
        vq.push_back(v);
    endtask

    task automatic set_cpu(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
        cpu_valid = 1'b1; cpu_we = we; cpu_size = size; cpu_unsigned = uns;
        cpu_addr = addr; cpu_wdata = wdata;
    endtask

    task automatic idle_cpu();
        cpu_valid = 1'b0; cpu_we = 1'b0; cpu_size = 2'b00; cpu_unsigned = 1'b0;
        cpu_addr = '0; cpu_wdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Called just after a clock edge with the controller in IDLE.
    task automatic run_access(input vec_t v);
        int  cyc, req_cycles;
        bit  granted, rv_sent, done;
        set_cpu(v.we, v.size, v.uns, v.addr, v.wdata);
        dm_if.gnt = 1'b0; dm_if.rvalid = 1'b0; dm_if.rdata = v.rdata;
        #1;
        chk({v.name, " stall_idle"}, {31'd0, stall}, 32'd1);
        cyc = 1; req_cycles = 0; granted = 0; rv_sent = 0; done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            next_cycle();
            cyc++;
            dm_if.gnt = 1'b0;
            dm_if.rvalid = 1'b0;
            if (granted && !v.we && !rv_sent) begin
                dm_if.rvalid = 1'b1;
                rv_sent = 1;
            end
            if (dm_if.req) begin
                if (req_cycles == 0) begin
                    chk({v.name, " be"},    {28'd0, dm_if.be}, {28'd0, v.be});
                    chk({v.name, " addr"},  dm_if.addr, v.exp_addr);
                    chk({v.name, " wdata"}, dm_if.wdata, v.exp_wdata);
                    chk({v.name, " we"},    {31'd0, dm_if.we}, {31'd0, v.we});
                end
                req_cycles++;
                if (!granted) begin
                    dm_if.gnt = 1'b1;
                    granted = 1;
                end
            end
            if (cpu_done) begin
                done = 1;
                chk({v.name, " latency"}, cyc, v.lat);
                chk({v.name, " err"},     {31'd0, cpu_err}, {31'd0, v.err});
                chk({v.name, " rdata"},   cpu_rdata, v.exp_rdata);
                chk({v.name, " stall_done"}, {31'd0, stall}, 32'd0);
                idle_cpu();
            end
        end
        if (!done) chk({v.name, " done_seen"}, 32'd0, 32'd1);
        chk({v.name, " req_cycles"}, req_cycles, v.err ? 0 : 1);
        dm_if.gnt = 1'b0; dm_if.rvalid = 1'b0;
        next_cycle();
    endtask

    initial begin
        int  req_cycles, cyc;
        bit  done;

        add("sw",   1, 2'b10, 0, 32'h100, 32'h12345678, 32'h0,        4'b1111, 32'h100, 32'h12345678, 32'h0,        0, 3);
        add("sb",   1, 2'b00, 0, 32'h103, 32'h000000AB, 32'h0,        4'b1000, 32'h100, 32'hABABABAB, 32'h0,        0, 3);
        add("sh",   1, 2'b01, 0, 32'h102, 32'hBEEF1234, 32'h0,        4'b1100, 32'h100, 32'h12341234, 32'h0,        0, 3);
        add("sb0",  1, 2'b00, 0, 32'h0F0, 32'h11223344, 32'h0,        4'b0001, 32'h0F0, 32'h44444444, 32'h0,        0, 3);
        add("lb",   0, 2'b00, 0, 32'h102, 32'h0,        32'h80FF7F00, 4'b1111, 32'h100, 32'h0,        32'hFFFFFFFF, 0, 4);
        add("lbu",  0, 2'b00, 1, 32'h102, 32'h0,        32'h80FF7F00, 4'b1111, 32'h100, 32'h0,        32'h000000FF, 0, 4);
        add("lb1",  0, 2'b00, 0, 32'h101, 32'h0,        32'h80FF7F00, 4'b1111, 32'h100, 32'h0,        32'h0000007F, 0, 4);
        add("lh",   0, 2'b01, 0, 32'h102, 32'h0,        32'h80FF7F00, 4'b1111, 32'h100, 32'h0,        32'hFFFF80FF, 0, 4);
        add("lhu",  0, 2'b01, 1, 32'h102, 32'h0,        32'h80FF7F00, 4'b1111, 32'h100, 32'h0,        32'h000080FF, 0, 4);
        add("lh0",  0, 2'b01, 0, 32'h100, 32'h0,        32'h80FF7F00, 4'b1111, 32'h100, 32'h0,        32'h00007F00, 0, 4);
        add("lw",   0, 2'b10, 1, 32'h204, 32'h0,        32'hDEADBEEF, 4'b1111, 32'h204, 32'h0,        32'hDEADBEEF, 0, 4);
        add("lh_mis", 0, 2'b01, 0, 32'h101, 32'h0,      32'h80FF7F00, 4'b0000, 32'h0,   32'h0,        32'h0,        1, 2);
        add("sw_mis", 1, 2'b10, 0, 32'h102, 32'h55AA55AA, 32'h0,      4'b0000, 32'h0,   32'h0,        32'h0,        1, 2);
        add("ill",  0, 2'b11, 0, 32'h100, 32'h0,        32'h12345678, 4'b0000, 32'h0,   32'h0,        32'h0,        1, 2);

        // Reset with a pending request: everything, stall included, reads 0.
        reset = 1'b1;
        set_cpu(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        dm_if.gnt = 1'b0; dm_if.rvalid = 1'b0; dm_if.rdata = '0;
        next_cycle();
        next_cycle();
        chk("reset outs", {stall, cpu_done, cpu_err, dm_if.req, dm_if.we, dm_if.be, 25'd0}, 32'd0);
        chk("reset rdata", cpu_rdata, 32'd0);
        reset = 1'b0;
        idle_cpu();
        next_cycle();
        chk("idle stall", {31'd0, stall}, 32'd0);

        foreach (vq[k]) run_access(vq[k]);

        // Load with gnt held low: four request cycles, then a timeout error.
        set_cpu(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        dm_if.rdata = 32'h13579BDF;
        req_cycles = 0; cyc = 1; done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            next_cycle();
            cyc++;
            if (dm_if.req) req_cycles++;
            if (cpu_done) begin
                done = 1;
                chk("to err",   {31'd0, cpu_err}, 32'd1);
                chk("to rdata", cpu_rdata, 32'd0);
                chk("to lat",   cyc, 6);
                idle_cpu();
            end
        end
        if (!done) chk("to done_seen", 32'd0, 32'd1);
        chk("to req_cycles", req_cycles, 4);
        next_cycle();
        chk("to back_idle", {30'd0, stall, cpu_done}, 32'd0);

        // gnt lands on the timeout cycle: handshake wins and the load completes.
        set_cpu(1'b0, 2'b10, 1'b0, 32'h104, 32'h0);
        dm_if.rdata = 32'hCAFEF00D;
        req_cycles = 0; done = 0;
        for (int i = 0; i < 20 && req_cycles < 4; i++) begin
            next_cycle();
            dm_if.gnt = 1'b0;
            if (dm_if.req) begin
                req_cycles++;
                if (req_cycles == 4) dm_if.gnt = 1'b1;
            end
        end
        next_cycle();
        dm_if.gnt = 1'b0;
        chk("tg wait_r", {29'd0, dm_if.req, stall, cpu_done}, 32'b010);
        dm_if.rvalid = 1'b1;
        next_cycle();
        dm_if.rvalid = 1'b0;
        chk("tg done",  {30'd0, cpu_done, cpu_err}, 32'b10);
        chk("tg rdata", cpu_rdata, 32'hCAFEF00D);
        idle_cpu();
        next_cycle();

        // Reset while waiting for read data, then a late rvalid.
        set_cpu(1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
        dm_if.rdata = 32'hFFFF0000;
        next_cycle();
        chk("rw req", {31'd0, dm_if.req}, 32'd1);
        dm_if.gnt = 1'b1;
        next_cycle();
        dm_if.gnt = 1'b0;
        chk("rw in_wait", {30'd0, stall, dm_if.req}, 32'b10);
        reset = 1'b1;
        #1;
        chk("rw reset outs", {stall, cpu_done, cpu_err, dm_if.req, dm_if.we, dm_if.be, 25'd0}, 32'd0);
        chk("rw reset rdata", cpu_rdata, 32'd0);
        next_cycle();
        reset = 1'b0;
        idle_cpu();
        dm_if.rvalid = 1'b1;
        #1;
        chk("rw late_rv", {30'd0, cpu_done, stall}, 32'd0);
        next_cycle();
        dm_if.rvalid = 1'b0;
        chk("rw after", {30'd0, cpu_done, stall}, 32'd0);
        chk("rw rdata", cpu_rdata, 32'd0);
        next_cycle();

        begin
            vec_t v;
            v = '{"lw_post", 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 32'h0BADC0DE,
                  4'b1111, 32'h200, 32'h0, 32'h0BADC0DE, 1'b0, 4};
            run_access(v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
